// File: rtl/event_stream_packer_if.sv
// Event-record input and framed byte output of the event stream packer.
// Latency: none, this is wiring only.
// Backpressure: tx_ready stalls the byte stream; evt_pop is a one-cycle strobe to a FWFT FIFO.
//
// Signals:
//   evt_data  - head-of-FIFO event record (first-word-fall-through)
//   evt_valid - FIFO non-empty
//   evt_pop   - one-cycle pop strobe back to the FIFO
//   tx_data   - framed stream byte
//   tx_valid  - tx_data is valid
//   tx_ready  - sink accepts the byte this cycle
// Modports: master = the packer, slave = FIFO plus byte sink.
interface event_stream_packer_if #(
  parameter int unsigned EVT_W = 72
);
  logic [EVT_W-1:0] evt_data;
  logic             evt_valid;
  logic             evt_pop;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    input  evt_data,
    input  evt_valid,
    input  tx_ready,
    output evt_pop,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output evt_data,
    output evt_valid,
    output tx_ready,
    input  evt_pop,
    input  tx_data,
    input  tx_valid
  );
endinterface

// File: rtl/event_stream_packer.sv
// Pops event records from a FWFT FIFO and emits SYNC, SEQ, payload (MSB-first), XOR checksum.
// Latency: first SYNC byte is valid the cycle after evt_pop; one byte per cycle; one idle bubble between frames.
// Backpressure: tx_ready low holds tx_data/tx_valid stable; no new pop until the current frame's checksum fires.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   en          - permit starting new frames (an in-flight frame always completes)
//   bus         - event_stream_packer_if master: evt_data/evt_valid/evt_pop, tx_data/tx_valid/tx_ready
//   busy        - high in any state other than IDLE
//   seq_num     - sequence number the next frame will carry
//   frames_sent - count of completed frames, wraps
module event_stream_packer #(
  parameter int unsigned EVT_W     = 72,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  event_stream_packer_if.master bus,
  output logic                 busy,
  output logic [7:0]           seq_num,
  output logic [CNT_W-1:0]     frames_sent
);

  localparam int unsigned NBYTES = (EVT_W + 7) / 8;
  localparam int unsigned PW     = NBYTES * 8;
  // Keep the index at least one bit wide so single-byte payloads elaborate.
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SEQ,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_pw;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_csum;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic [7:0]       r_seq;
  logic [CNT_W-1:0] r_frames;

  logic             w_fire;
  logic             w_pop;

  assign w_fire = r_tx_valid & bus.tx_ready;

  // The pop has to coincide with the capture of the FWFT head, so it is
  // decoded from the registered state in the same cycle. Gating with rst_n
  // keeps a reset cycle from consuming an event it would then discard.
  assign w_pop = rst_n & en & bus.evt_valid & (r_state == S_IDLE);

  assign bus.evt_pop  = w_pop;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;

  assign busy        = (r_state != S_IDLE);
  assign seq_num     = r_seq;
  assign frames_sent = r_frames;

  // The payload register doubles as a shift register: the byte on the wire
  // is always taken from its top, and it shifts left by one byte per fire.
  // tx_data is registered, so each state prepares the byte for the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pw       <= '0;
      r_idx      <= '0;
      r_csum     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_seq      <= '0;
      r_frames   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_pw       <= PW'(bus.evt_data);
            r_tx_data  <= SYNC_BYTE;
            r_tx_valid <= 1'b1;
            r_state    <= S_SYNC;
          end
        end

        S_SYNC: begin
          if (w_fire) begin
            // SYNC is not covered by the checksum; it starts from the SEQ byte.
            r_tx_data <= r_seq;
            r_csum    <= r_seq;
            r_state   <= S_SEQ;
          end
        end

        S_SEQ: begin
          if (w_fire) begin
            r_tx_data <= r_pw[PW-1 -: 8];
            r_pw      <= r_pw << 8;
            r_idx     <= '0;
            r_state   <= S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          if (w_fire) begin
            r_csum <= r_csum ^ r_tx_data;
            if (r_idx == LAST_IDX) begin
              // Present the finished checksum straight away, folding in the
              // byte that is leaving this cycle.
              r_tx_data <= r_csum ^ r_tx_data;
              r_state   <= S_CSUM;
            end else begin
              r_tx_data <= r_pw[PW-1 -: 8];
              r_pw      <= r_pw << 8;
              r_idx     <= r_idx + IDX_W'(1);
            end
          end
        end

        S_CSUM: begin
          if (w_fire) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_seq      <= r_seq + 8'd1;
            r_frames   <= r_frames + CNT_W'(1);
            r_state    <= S_IDLE;
          end
        end

        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_stream_packer.sv
`timescale 1ns/1ps
module tb_event_stream_packer;

  localparam logic [1:0] K_SYNC = 2'd0;
  localparam logic [1:0] K_SEQ  = 2'd1;
  localparam logic [1:0] K_PAY  = 2'd2;
  localparam logic [1:0] K_CSUM = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_a, en_b;
  logic        busy_a, busy_b;
  logic [7:0]  seq_a, seq_b;
  logic [15:0] frames_a, frames_b;

  event_stream_packer_if #(.EVT_W(72)) bus_a ();
  event_stream_packer_if #(.EVT_W(20)) bus_b ();

  event_stream_packer #(.EVT_W(72), .SYNC_BYTE(8'hA5), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .bus(bus_a),
    .busy(busy_a), .seq_num(seq_a), .frames_sent(frames_a)
  );

  event_stream_packer #(.EVT_W(20), .SYNC_BYTE(8'hA5), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .bus(bus_b),
    .busy(busy_b), .seq_num(seq_b), .frames_sent(frames_b)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pops_a = 0;
  int          pops_b = 0;
  int          fire_a = 0;
  bit          rdy_random = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_dat = 8'h00;
  logic [7:0]  last_seq_a = 8'hFF;
  logic [7:0]  model_seq = 8'h00;
  exp_t        expa[$];
  exp_t        expb[$];
  logic [71:0] evq[$];
  int          sync_cyc[$];
  int          csum_cyc[$];
  int          pop_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_a(input logic [1:0] k, input logic [7:0] b);
    exp_t e;
    e.kind = k;
    e.b    = b;
    expa.push_back(e);
  endtask

  task automatic push_b(input logic [1:0] k, input logic [7:0] b);
    exp_t e;
    e.kind = k;
    e.b    = b;
    expb.push_back(e);
  endtask

  // Reference frame for a 72-bit record: 9 payload bytes MSB-first.
  task automatic push_frame_a(input logic [71:0] d, input logic [7:0] s);
    logic [7:0] cs;
    logic [7:0] by;
    push_a(K_SYNC, 8'hA5);
    push_a(K_SEQ, s);
    cs = s;
    for (int i = 0; i < 9; i++) begin
      by = d[8*(8-i) +: 8];
      cs = cs ^ by;
      push_a(K_PAY, by);
    end
    push_a(K_CSUM, cs);
  endtask

  task automatic drive_fifo();
    bus_a.evt_valid = (evq.size() > 0);
    bus_a.evt_data  = (evq.size() > 0) ? evq[0] : 72'h0;
  endtask

  task automatic enqueue_a(input logic [71:0] d);
    evq.push_back(d);
    push_frame_a(d, model_seq);
    model_seq = model_seq + 8'd1;
    drive_fifo();
  endtask

  // One clock: sample and score at the falling edge, update stimulus just after the rising edge.
  task automatic tick();
    logic pa, pb, fa, fb;
    exp_t e;
    @(negedge clk);
    cyc++;
    pa = bus_a.evt_pop;
    pb = bus_b.evt_pop;
    fa = bus_a.tx_valid && bus_a.tx_ready;
    fb = bus_b.tx_valid && bus_b.tx_ready;
    if (pa) begin
      pops_a++;
      pop_cyc.push_back(cyc);
      check("a_pop_needs_valid", 32'(bus_a.evt_valid), 32'd1);
    end
    if (pb) begin
      pops_b++;
      check("b_pop_needs_valid", 32'(bus_b.evt_valid), 32'd1);
    end
    if (prev_stall) begin
      check("a_stall_valid_held", 32'(bus_a.tx_valid), 32'd1);
      check("a_stall_data_held", 32'(bus_a.tx_data), 32'(prev_dat));
    end
    prev_stall = bus_a.tx_valid && !bus_a.tx_ready;
    prev_dat   = bus_a.tx_data;
    if (fa) begin
      fire_a++;
      check("a_sb_has_entry", 32'(expa.size() > 0), 32'd1);
      if (expa.size() > 0) begin
        e = expa.pop_front();
        check("a_byte", 32'(bus_a.tx_data), 32'(e.b));
        if (e.kind == K_SYNC) sync_cyc.push_back(cyc);
        if (e.kind == K_SEQ)  last_seq_a = bus_a.tx_data;
        if (e.kind == K_CSUM) csum_cyc.push_back(cyc);
      end
    end
    if (fb) begin
      check("b_sb_has_entry", 32'(expb.size() > 0), 32'd1);
      if (expb.size() > 0) begin
        e = expb.pop_front();
        check("b_byte", 32'(bus_b.tx_data), 32'(e.b));
      end
    end
    @(posedge clk);
    #1;
    if (pa && evq.size() > 0) evq.delete(0);
    drive_fifo();
    if (pb) bus_b.evt_valid = 1'b0;
    bus_a.tx_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_a(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (expa.size() == 0 && evq.size() == 0 && !busy_a && !bus_a.tx_valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    logic [7:0] f1 [12];
    logic [7:0] f5 [6];
    int p0, fr0, f0;
    bit done;

    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    bus_a.evt_valid = 1'b0;
    bus_a.evt_data  = 72'h0;
    bus_a.tx_ready  = 1'b1;
    bus_b.evt_valid = 1'b0;
    bus_b.evt_data  = 20'h0;
    bus_b.tx_ready  = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_tx_valid", 32'(bus_a.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus_a.tx_data), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_seq", 32'(seq_a), 32'd0);
    check("rst_frames", 32'(frames_a), 32'd0);
    check("rst_evt_pop", 32'(bus_a.evt_pop), 32'd0);
    check("rst_b_tx_valid", 32'(bus_b.tx_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single frame with the reference record
    en_a = 1'b1;
    p0 = pops_a;
    sync_cyc.delete();
    csum_cyc.delete();
    pop_cyc.delete();
    f1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h3C, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h1B};
    for (int i = 0; i < 12; i++)
      push_a((i == 0) ? K_SYNC : (i == 1) ? K_SEQ : (i == 11) ? K_CSUM : K_PAY, f1[i]);
    evq.push_back(72'h00000005_3C_DEADBEEF);
    model_seq = 8'd1;
    drive_fifo();
    wait_a(40, "t1_done");
    check("t1_pops", 32'(pops_a - p0), 32'd1);
    check("t1_frames", 32'(frames_a), 32'd1);
    check("t1_seq", 32'(seq_a), 32'd1);
    check("t1_one_sync", 32'(sync_cyc.size()), 32'd1);
    check("t1_one_csum", 32'(csum_cyc.size()), 32'd1);
    check("t1_pop_to_sync", 32'(sync_cyc[0] - pop_cyc[0]), 32'd1);
    check("t1_12_consecutive", 32'(csum_cyc[0] - sync_cyc[0]), 32'd11);

    // Same record under random backpressure
    p0 = pops_a;
    rdy_random = 1'b1;
    enqueue_a(72'h00000005_3C_DEADBEEF);
    wait_a(300, "t2_done");
    rdy_random = 1'b0;
    tick();
    check("t2_pops", 32'(pops_a - p0), 32'd1);
    check("t2_frames", 32'(frames_a), 32'd2);
    check("t2_seq", 32'(seq_a), 32'd2);

    // Three queued events, back to back
    p0 = pops_a;
    sync_cyc.delete();
    enqueue_a(72'h12_3456_789A_BCDE_F011);
    enqueue_a(72'hFF_0000_FFFF_0000_8001);
    enqueue_a(72'h5A_A55A_A55A_A55A_C3C3);
    wait_a(100, "t3_done");
    check("t3_pops", 32'(pops_a - p0), 32'd3);
    check("t3_frames", 32'(frames_a), 32'd5);
    check("t3_seq", 32'(seq_a), 32'd5);
    check("t3_three_syncs", 32'(sync_cyc.size()), 32'd3);
    check("t3_spacing_01", 32'(sync_cyc[1] - sync_cyc[0]), 32'd13);
    check("t3_spacing_12", 32'(sync_cyc[2] - sync_cyc[1]), 32'd13);

    // Sequence wrap over 257 frames from a fresh reset
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    model_seq = 8'd0;
    p0 = pops_a;
    for (int i = 0; i < 257; i++)
      enqueue_a({8'(i), $urandom, $urandom});
    wait_a(257 * 13 + 60, "t4_done");
    check("t4_pops", 32'(pops_a - p0), 32'd257);
    check("t4_frames", 32'(frames_a), 32'd257);
    check("t4_seq", 32'(seq_a), 32'd1);
    check("t4_last_seq_byte", 32'(last_seq_a), 32'd0);

    // 20-bit record: padded to 3 bytes
    f5 = '{8'hA5, 8'h00, 8'h0A, 8'hBC, 8'hDE, 8'h68};
    for (int i = 0; i < 6; i++)
      push_b((i == 0) ? K_SYNC : (i == 1) ? K_SEQ : (i == 5) ? K_CSUM : K_PAY, f5[i]);
    bus_b.evt_data  = 20'hABCDE;
    bus_b.evt_valid = 1'b1;
    en_b = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (expb.size() == 0 && !busy_b && !bus_b.evt_valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("t5_done", 32'(done), 32'd1);
    check("t5_pops", 32'(pops_b), 32'd1);
    check("t5_frames", 32'(frames_b), 32'd1);
    check("t5_seq", 32'(seq_b), 32'd1);

    // en low with an event waiting: no pop, no output
    en_a = 1'b0;
    p0 = pops_a;
    fr0 = frames_a;
    enqueue_a(72'hC0_FFEE_DDCC_BBAA_9988);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_en0_tx_valid", 32'(bus_a.tx_valid), 32'd0);
    end
    check("t6_en0_no_pop", 32'(pops_a - p0), 32'd0);

    // Enable, then drop en in the middle of the payload
    en_a = 1'b1;
    f0 = fire_a;
    for (int i = 0; i < 40 && fire_a < f0 + 4; i++) tick();
    check("t6_reach_payload", 32'(fire_a >= f0 + 4), 32'd1);
    en_a = 1'b0;
    enqueue_a(72'h01_0203_0405_0607_0809);
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy_a && expa.size() == 12) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("t6_frame_completes", 32'(done), 32'd1);
    repeat (4) tick();
    check("t6_frames_after_drop", 32'(frames_a - fr0), 32'd1);
    check("t6_pops_after_drop", 32'(pops_a - p0), 32'd1);
    check("t6_idle_tx_valid", 32'(bus_a.tx_valid), 32'd0);
    en_a = 1'b1;
    wait_a(40, "t6_second_done");
    check("t6_frames_second", 32'(frames_a - fr0), 32'd2);

    // Reset in the middle of the payload
    enqueue_a(72'hAB_CDEF_0123_4567_89AB);
    f0 = fire_a;
    for (int i = 0; i < 40 && fire_a < f0 + 5; i++) tick();
    check("t6_reach_payload_rst", 32'(fire_a >= f0 + 5), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_tx_valid", 32'(bus_a.tx_valid), 32'd0);
    check("t6_rst_seq", 32'(seq_a), 32'd0);
    check("t6_rst_frames", 32'(frames_a), 32'd0);
    check("t6_rst_busy", 32'(busy_a), 32'd0);
    expa.delete();
    model_seq = 8'd0;
    rst_n = 1'b1;
    tick();
    enqueue_a(72'h77_6655_4433_2211_0000);
    wait_a(40, "t6_after_rst_done");
    check("t6_after_rst_seq_byte", 32'(last_seq_a), 32'd0);
    check("t6_after_rst_frames", 32'(frames_a), 32'd1);
    check("t6_after_rst_seq", 32'(seq_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/event_stream_packer.md
Name: event_stream_packer

Overview:
- Downstream consumer of the event monitor's capture FIFO.
- Pops one event record at a time and serialises it into a framed byte stream for the debug UART/host link.
- Output is a valid/ready byte interface.
- Frame layout: SYNC byte, 8-bit sequence number, event payload bytes MSB-first, XOR checksum byte.

Parameters:
- EVT_W, 72, width of one event record ({ts, probe_id, probe_data}); must be >= 1.
- SYNC_BYTE, 8'hA5, constant first byte of every frame.
- CNT_W, 16, width of the frames_sent counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  permit starting new frames; an in-flight frame always completes
- evt_data  input  EVT_W  head-of-FIFO event record; valid whenever evt_valid=1 (first-word-fall-through)
- evt_valid  input  1  FIFO non-empty
- evt_pop  output  1  one-cycle pop strobe to the FIFO
- tx_data  output  8  stream byte
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  sink accepts the byte this cycle
- busy  output  1  high in any state other than IDLE
- seq_num  output  8  sequence number the next frame will carry
- frames_sent  output  CNT_W  completed frames; wraps

Behaviour:
- NBYTES = ceil(EVT_W/8).
- Payload register PW = NBYTES*8 bits, loaded with evt_data zero-extended on the MSB side.
- Payload bytes are sent from PW[PW-1 -: 8] down to PW[7:0].
- Reset values: evt_pop=0, tx_valid=0, tx_data=0, busy=0, seq_num=0, frames_sent=0, checksum=0, state=IDLE. All are synchronous to clk.
- State machine: IDLE -> SYNC -> SEQ -> PAYLOAD -> CSUM -> IDLE.
- A byte "fires" on any cycle where tx_valid && tx_ready.
- IDLE:
  - tx_valid=0.
  - If en && evt_valid: assert evt_pop for exactly that cycle, capture evt_data into PW the same cycle, go to SYNC.
  - evt_pop is never asserted outside IDLE, and never when evt_valid=0.
- SYNC: tx_valid=1, tx_data=SYNC_BYTE. On fire -> SEQ.
- SEQ:
  - tx_data=seq_num; checksum is initialised to seq_num.
  - On fire -> PAYLOAD, byte index=0.
- PAYLOAD:
  - tx_data = current payload byte.
  - On fire: checksum ^= byte, index++.
  - After byte NBYTES-1 fires -> CSUM.
- CSUM:
  - tx_data = checksum, i.e. the XOR of the SEQ byte and all payload bytes; SYNC is excluded.
  - On fire: seq_num <= seq_num+1 (mod 256), frames_sent <= frames_sent+1 (mod 2^CNT_W), go to IDLE.
- Stream rules:
  - While tx_valid=1 && tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a fire, except on reset.
  - tx_ready while tx_valid=0 is ignored.
- Latency and throughput:
  - First SYNC byte is valid the cycle after evt_pop.
  - Frame length is NBYTES+3 bytes: 12 for EVT_W=72.
  - With tx_ready held at 1, one byte per cycle, plus one IDLE bubble cycle between frames. Back-to-back frames therefore have a period of NBYTES+4 cycles.
- en deasserted mid-frame: the frame completes normally; no new pop occurs while en=0.
- Reset mid-frame: the frame is abandoned, tx_valid=0 next cycle, all counters return to 0. The already-popped event is lost; this is intentional.
- evt_data changes while in a non-IDLE state have no effect on the frame in progress, because PW was captured at pop.
- busy=1 from the cycle after the pop through the CSUM fire cycle.

Test Plan:
1. Single frame, EVT_W=72, evt_data=72'h00000005_3C_DEADBEEF, tx_ready=1 -> one evt_pop pulse; bytes A5 00 00 00 00 05 3C DE AD BE EF 1B on 12 consecutive cycles; frames_sent=1, seq_num=1.
2. Backpressure: same event, tx_ready toggled 1,0,0,1,... pseudo-randomly -> identical byte sequence; tx_data stable on every stalled cycle; no extra evt_pop.
3. Back-to-back: 3 events queued in a FIFO model, tx_ready=1 -> exactly 3 pops; SEQ bytes 00, 01, 02; frame start spacing of 13 cycles; checksum of each frame is correct.
4. Sequence wrap: run 257 frames -> the 257th frame carries SEQ byte 00; frames_sent=257.
5. Padding: EVT_W=20, evt_data=20'hABCDE -> bytes A5 00 0A BC DE, then checksum 00^0A^BC^DE=68.
6. Control and reset:
   - en=0 with evt_valid=1 -> no pop, tx_valid=0.
   - Drop en during PAYLOAD -> the frame still completes.
   - Assert rst_n=0 during PAYLOAD -> tx_valid=0, seq_num=0, frames_sent=0 the following cycle, and the next frame starts with SEQ 00.
